alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
Shares one 16-bit combinational ALU between two requesters (port 0, port 1) using round-robin arbitration. Each requester issues commands over a valid/ready handshake: opcode plus two operands. The arbiter registers the winning command, drives the ALU for one cycle, captures the result, and returns it on that requester's response channel. It sits between the ALU and its users, for example the decode/execute stage and a microcoded helper.

Parameters:
WIDTH, 16, operand/result width; must match ALU width
OPW, 3, opcode width
ALU opcode encoding (passed through unchanged): 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
req0_valid  in  1  port 0 command valid
req0_ready  out  1  port 0 command accepted this cycle when valid&ready
req0_op  in  OPW  port 0 opcode
req0_x  in  WIDTH  port 0 operand x
req0_y  in  WIDTH  port 0 operand y
req1_valid/req1_ready/req1_op/req1_x/req1_y  same as port 0, for port 1
rsp0_valid  out  1  port 0 result valid
rsp0_ready  in  1  port 0 result consumed when valid&ready
rsp0_data  out  WIDTH  port 0 result
rsp1_valid/rsp1_ready/rsp1_data  same as port 0, for port 1
alu_op  out  OPW  opcode to ALU
alu_x  out  WIDTH  operand x to ALU
alu_y  out  WIDTH  operand y to ALU
alu_s  in  WIDTH  ALU result (combinational from alu_op/x/y)

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- FSM states: IDLE, EXEC, RESP. Reset → IDLE.
- Reset values: last_grant=1 (port 0 wins first tie), state=IDLE; all registered op/operands/result = 0; every output 0.
- IDLE:
  - req0_ready/req1_ready are combinational: only the arbitration winner sees ready=1.
  - Winner = sole valid requester; if both valid, the port not equal to last_grant.
  - On handshake: latch op/x/y and the owner ID, set last_grant=owner, go to EXEC.
  - No valid request: stay in IDLE, both ready=0.
- EXEC (exactly 1 cycle):
  - alu_op/alu_x/alu_y driven from latched registers.
  - alu_s captured into result register at end of cycle; go to RESP.
  - Both req*_ready=0.
- RESP:
  - rsp<owner>_valid=1 and rsp<owner>_data=result register, both held stable until rsp<owner>_ready=1.
  - On handshake, go to IDLE. Other port's rsp_valid stays 0. Both req*_ready=0.
- ALU outputs outside EXEC: alu_op/x/y hold the latched values (no glitching to 0 needed). After reset they are 0.
- Latency: request handshake in cycle N → rsp_valid asserted in cycle N+2. Max throughput is one op per 3 cycles with rsp_ready tied high.
- Fairness: with both ports continuously valid, grants strictly alternate 0,1,0,1…
- Responder stall: an owner holding rsp_ready=0 blocks the arbiter indefinitely. This is accepted; no timeout.
- Reset mid-operation (EXEC or RESP): in-flight command dropped, no response issued, state → IDLE, last_grant → 1.
- Command ports do not need to keep valid asserted after a handshake. Operand changes after acceptance have no effect.
- Width rules:
  - Result is the ALU's WIDTH-bit output unchanged; no carry or overflow is exported.
  - SLT result bit 0 is supplied by the ALU; the arbiter does not interpret opcodes.
  - Undefined opcodes are passed through, and whatever alu_s returns is reported.

Optional Feature:
ALU_ZERO_FLAG_EN
- Defined: adds outputs rsp0_zero and rsp1_zero (1 bit each).
  - Registered alongside the result in EXEC as (alu_s == 0).
  - Valid only with the corresponding rsp_valid; 0 otherwise and at reset.
- Undefined: ports absent, no extra logic.

Test Plan:
- Reset, then port 0 issues op=010 x=0x0003 y=0x0004, rsp0_ready=1 → req0_ready=1 in cycle N; alu_op=010, alu_x=0x0003 in N+1; rsp0_valid=1, rsp0_data=0x0007 in N+2; rsp1_valid=0 throughout.
- Both ports valid from first cycle after reset, port 0 op=000 x=0x00FF y=0x0F0F, port 1 op=001 same operands → port 0 granted first (rsp0_data=0x000F), then port 1 (rsp1_data=0x0FFF); fifth op also alternates (0,1,0,1,0).
- Port 1 op=110 x=0x0005 y=0x0007, rsp1_ready held 0 for 5 cycles → rsp1_valid and rsp1_data=0xFFFE held stable; req0_ready stays 0 for a waiting port 0 until rsp1 handshake, then grant in the next IDLE cycle.
- Reset asserted during EXEC of a port 0 ADD → no rsp0_valid ever appears for it; next cycle after reset deassertion state is IDLE, all outputs 0; a new port 1 request is then granted normally.
- With ALU_ZERO_FLAG_EN: port 0 op=110 x=0x1234 y=0x1234 → rsp0_data=0x0000, rsp0_zero=1; op=001 x=0x0000 y=0x0001 → rsp0_zero=0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Each accepted command is registered, executed for one cycle, and its result
// is returned on the owning port's response channel.
// Optional build macro: ALU_ZERO_FLAG_EN adds rsp0_zero/rsp1_zero outputs.
module alu_share_arbiter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned OPW   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
`ifdef ALU_ZERO_FLAG_EN
  output logic             rsp0_zero,
  output logic             rsp1_zero,
`endif
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  input  logic [WIDTH-1:0] alu_s
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             owner;
  logic             last_grant;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] result_q;
`ifdef ALU_ZERO_FLAG_EN
  logic             zero_q;
`endif

  logic any_valid_c;
  logic winner_c;
  logic accept_c;
  logic owner_rsp_ready_c;

  // Arbitration: sole requester wins; on a tie the port that did not win last
  assign any_valid_c       = req0_valid | req1_valid;
  assign winner_c          = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
  assign owner_rsp_ready_c = owner ? rsp1_ready : rsp0_ready;

  // Next-state logic and combinational command-ready outputs
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept_c   = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid_c) begin
          req0_ready = ~winner_c;
          req1_ready = winner_c;
          accept_c   = 1'b1;
          state_nxt  = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        if (owner_rsp_ready_c) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, command latch and result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      op_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      result_q   <= '0;
`ifdef ALU_ZERO_FLAG_EN
      zero_q     <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept_c) begin
        owner      <= winner_c;
        last_grant <= winner_c;
        op_q       <= winner_c ? req1_op : req0_op;
        x_q        <= winner_c ? req1_x  : req0_x;
        y_q        <= winner_c ? req1_y  : req0_y;
      end
      if (state == EXEC) begin
        result_q <= alu_s;
`ifdef ALU_ZERO_FLAG_EN
        zero_q   <= (alu_s == '0);
`endif
      end
    end
  end

  // ALU is driven straight from the latched command; it holds between ops
  assign alu_op = op_q;
  assign alu_x  = x_q;
  assign alu_y  = y_q;

  // Response channel of the owning port only
  assign rsp0_valid = (state == RESP) & ~owner;
  assign rsp1_valid = (state == RESP) & owner;
  assign rsp0_data  = result_q;
  assign rsp1_data  = result_q;
`ifdef ALU_ZERO_FLAG_EN
  assign rsp0_zero  = zero_q & rsp0_valid;
  assign rsp1_zero  = zero_q & rsp1_valid;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus randomized traffic,
// checked against a transaction-level model (fair-grant rule + ALU arithmetic).
// Build with +define+ALU_ZERO_FLAG_EN to also check the zero flags.
module tb_alu_share_arbiter;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned OPW   = 3;

  logic             clk;
  logic             reset;
  logic             req0_valid, req0_ready;
  logic [OPW-1:0]   req0_op;
  logic [WIDTH-1:0] req0_x, req0_y;
  logic             req1_valid, req1_ready;
  logic [OPW-1:0]   req1_op;
  logic [WIDTH-1:0] req1_x, req1_y;
  logic             rsp0_valid, rsp0_ready;
  logic [WIDTH-1:0] rsp0_data;
  logic             rsp1_valid, rsp1_ready;
  logic [WIDTH-1:0] rsp1_data;
`ifdef ALU_ZERO_FLAG_EN
  logic             rsp0_zero, rsp1_zero;
`endif
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_x, alu_y, alu_s;

  int checks;
  int errors;
  int exp_last;  // port granted most recently (1 after reset)

  // Reference ALU arithmetic; undefined opcodes get arbitrary but fixed results
  function automatic logic [WIDTH-1:0] alu_ref(input logic [OPW-1:0] op,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    case (op)
      3'b000:  return x & y;
      3'b001:  return x | y;
      3'b010:  return x + y;
      3'b110:  return x - y;
      3'b111:  return WIDTH'(($signed(x) < $signed(y)) ? 1 : 0);
      3'b011:  return x ^ y;
      3'b100:  return ~x;
      default: return x << 1;
    endcase
  endfunction

  assign alu_s = alu_ref(alu_op, alu_x, alu_y);

  alu_share_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_x(req0_x), .req0_y(req0_y),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_x(req1_x), .req1_y(req1_y),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
`ifdef ALU_ZERO_FLAG_EN
    .rsp0_zero(rsp0_zero), .rsp1_zero(rsp1_zero),
`endif
    .alu_op(alu_op), .alu_x(alu_x), .alu_y(alu_y), .alu_s(alu_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = '0; req0_x = '0; req0_y = '0;
    req1_op = '0; req1_x = '0; req1_y = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_last = 1;
  endtask

  // One command: drive in IDLE, check grant, EXEC drive, RESP hold, handshake.
  // Entered and left at posedge+1 with the DUT in IDLE.
  task automatic run_op(input logic v0, input logic v1,
                        input logic [OPW-1:0] op0, input logic [WIDTH-1:0] x0,
                        input logic [WIDTH-1:0] y0,
                        input logic [OPW-1:0] op1, input logic [WIDTH-1:0] x1,
                        input logic [WIDTH-1:0] y1,
                        input int stall, output int granted);
    int w;
    logic [OPW-1:0]   eop;
    logic [WIDTH-1:0] ex, ey, eres;
    logic             ev0, ev1;
    req0_valid = v0; req0_op = op0; req0_x = x0; req0_y = y0;
    req1_valid = v1; req1_op = op1; req1_x = x1; req1_y = y1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    if (v0 && v1) w = (exp_last == 0) ? 1 : 0;
    else if (v0)  w = 0;
    else if (v1)  w = 1;
    else          w = -1;
    granted = w;
    @(negedge clk);
    checks++;
    if (req0_ready !== (w == 0) || req1_ready !== (w == 1)) begin
      errors++;
      $display("FAIL grant: ready0=%0b ready1=%0b required winner %0d", req0_ready, req1_ready, w);
    end
    checks++;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_rsp: rsp0_valid=%0b rsp1_valid=%0b required 0/0", rsp0_valid, rsp1_valid);
    end
    if (w < 0) begin
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
    end else begin
      eop  = (w == 1) ? op1 : op0;
      ex   = (w == 1) ? x1 : x0;
      ey   = (w == 1) ? y1 : y0;
      eres = alu_ref(eop, ex, ey);
      ev0  = (w == 0);
      ev1  = (w == 1);
      @(posedge clk); #1;
      // keep both ports requesting with scrambled operands: must not be accepted
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_op = OPW'($urandom); req0_x = WIDTH'($urandom); req0_y = WIDTH'($urandom);
      req1_op = OPW'($urandom); req1_x = WIDTH'($urandom); req1_y = WIDTH'($urandom);
      @(negedge clk);
      checks++;
      if (alu_op !== eop || alu_x !== ex || alu_y !== ey) begin
        errors++;
        $display("FAIL exec_alu: op=%h x=%h y=%h required op=%h x=%h y=%h", alu_op, alu_x, alu_y, eop, ex, ey);
      end
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
        errors++;
        $display("FAIL exec_ctrl: rdy=%0b%0b rspv=%0b%0b required 00 00", req0_ready, req1_ready, rsp0_valid, rsp1_valid);
      end
      for (int s = 0; s <= stall; s++) begin
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (rsp0_valid !== ev0 || rsp1_valid !== ev1) begin
          errors++;
          $display("FAIL rsp_valid: rsp0_valid=%0b rsp1_valid=%0b required %0b %0b (cycle %0d)", rsp0_valid, rsp1_valid, ev0, ev1, s);
        end
        checks++;
        if (((w == 0) ? rsp0_data : rsp1_data) !== eres) begin
          errors++;
          $display("FAIL rsp_data: got %h required %h (cycle %0d)", (w == 0) ? rsp0_data : rsp1_data, eres, s);
        end
`ifdef ALU_ZERO_FLAG_EN
        checks++;
        if (rsp0_zero !== (ev0 && eres == '0) || rsp1_zero !== (ev1 && eres == '0)) begin
          errors++;
          $display("FAIL rsp_zero: z0=%0b z1=%0b required %0b %0b", rsp0_zero, rsp1_zero, ev0 && eres == '0, ev1 && eres == '0);
        end
`endif
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
          errors++;
          $display("FAIL resp_ready: rdy0=%0b rdy1=%0b required 0 0", req0_ready, req1_ready);
        end
      end
      // non-owner ready is raised too; it must not matter
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      @(posedge clk); #1;
      idle_inputs();
      exp_last = w;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if (req0_ready !== 0 || req1_ready !== 0 || rsp0_valid !== 0 || rsp1_valid !== 0 ||
        rsp0_data !== '0 || rsp1_data !== '0 || alu_op !== '0 || alu_x !== '0 || alu_y !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%0b%0b rspv=%0b%0b d0=%h d1=%h alu=%h/%h/%h required all 0",
               req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data, alu_op, alu_x, alu_y);
    end
`ifdef ALU_ZERO_FLAG_EN
    checks++;
    if (rsp0_zero !== 0 || rsp1_zero !== 0) begin
      errors++;
      $display("FAIL reset_zero: z0=%0b z1=%0b required 0 0", rsp0_zero, rsp1_zero);
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_single_add();
    int g;
    apply_reset();
    run_op(1'b1, 1'b0, 3'b010, 16'h0003, 16'h0004, '0, '0, '0, 0, g);
    checks++;
    if (g != 0 || exp_last != 0) begin
      errors++;
      $display("FAIL single_add_owner: got %0d required 0", g);
    end
  endtask

  task automatic test_alternate();
    int g;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      run_op(1'b1, 1'b1, 3'b000, 16'h00FF, 16'h0F0F, 3'b001, 16'h00FF, 16'h0F0F, 0, g);
      checks++;
      if (g != (i % 2)) begin
        errors++;
        $display("FAIL alternate_order: op %0d granted %0d required %0d", i, g, i % 2);
      end
    end
  endtask

  task automatic test_stall();
    int g;
    run_op(1'b0, 1'b1, '0, '0, '0, 3'b110, 16'h0005, 16'h0007, 5, g);
    // port 0 has been waiting; it is granted in the first IDLE cycle
    run_op(1'b1, 1'b0, 3'b001, 16'h1200, 16'h0034, '0, '0, '0, 0, g);
    checks++;
    if (g != 0) begin
      errors++;
      $display("FAIL stall_followup: granted %0d required 0", g);
    end
  endtask

  task automatic test_reset_mid();
    int g;
    int seen;
    req0_valid = 1'b1; req0_op = 3'b010; req0_x = 16'h1111; req0_y = 16'h2222;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    @(posedge clk); #1;          // now in EXEC
    req0_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_last = 1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) seen++;
      if (c == 0) begin
        checks++;
        if (rsp0_data !== '0 || alu_op !== '0 || alu_x !== '0 || alu_y !== '0 ||
            req0_ready !== 0 || req1_ready !== 0) begin
          errors++;
          $display("FAIL reset_mid_outputs: d0=%h alu=%h/%h/%h rdy=%0b%0b required all 0",
                   rsp0_data, alu_op, alu_x, alu_y, req0_ready, req1_ready);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_mid_dropped: %0d response cycles seen required 0", seen);
    end
    idle_inputs();
    run_op(1'b0, 1'b1, '0, '0, '0, 3'b111, 16'hFFFF, 16'h0001, 1, g);
  endtask

  task automatic test_zero();
    int g;
    apply_reset();
    run_op(1'b1, 1'b0, 3'b110, 16'h1234, 16'h1234, '0, '0, '0, 0, g);
    run_op(1'b1, 1'b0, 3'b001, 16'h0000, 16'h0001, '0, '0, '0, 0, g);
  endtask

  task automatic test_random();
    int g;
    for (int i = 0; i < 60; i++) begin
      run_op(1'($urandom), 1'($urandom),
             OPW'($urandom), WIDTH'($urandom), WIDTH'($urandom),
             OPW'($urandom), WIDTH'($urandom), WIDTH'($urandom),
             int'($urandom_range(0, 3)), g);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_last = 1;
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_add();
    test_alternate();
    test_stall();
    test_reset_mid();
    test_zero();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
